// File: rtl/regfile_inexrecur.sv
// rtl/regfile_inexrecur.sv - append-only inexact-recursion register file with sequential and random registered reads
// Optional macro REGFILE_INEXRECUR_RD_VALID_EN adds the out_r_valid strobe.
module regfile_inexrecur #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [DATA_W-1:0] w_data,
    input  logic              seq_re,
    input  logic              ran_re,
    input  logic [ADDR_W-1:0] ran_r_addr,
    output logic [ADDR_W-1:0] out_r_addr,
    output logic [DATA_W-1:0] out_r_data
`ifdef REGFILE_INEXRECUR_RD_VALID_EN
    ,
    output logic              out_r_valid
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;

    logic              wr_ok;
    logic              ran_in_range;
    logic              seq_avail;
    logic              seq_fire;
    logic              rd_fire;
    logic [ADDR_W-1:0] rd_idx;
    logic [DATA_W-1:0] rd_data;

    // Bounds use the pointers from before this cycle's write, so a same-cycle
    // append is never visible to the read issued alongside it.
    always_comb begin
        wr_ok        = we && !wr_ptr[ADDR_W];
        ran_in_range = ({1'b0, ran_r_addr} < wr_ptr);
        seq_avail    = (rd_ptr < wr_ptr);
        seq_fire     = seq_re && !ran_re && seq_avail;
        rd_fire      = ran_re || seq_fire;
        rd_idx       = ran_re ? ran_r_addr : rd_ptr[ADDR_W-1:0];
        rd_data      = (ran_re && !ran_in_range) ? '0 : mem[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n && wr_ok) begin
            mem[wr_ptr[ADDR_W-1:0]] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            out_r_addr <= '0;
            out_r_data <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (seq_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                out_r_addr <= rd_idx;
                out_r_data <= rd_data;
            end
        end
    end

`ifdef REGFILE_INEXRECUR_RD_VALID_EN
    // Out-of-range random reads still update the outputs but are not valid.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            out_r_valid <= 1'b0;
        end else begin
            out_r_valid <= ran_re ? ran_in_range : seq_fire;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_inexrecur.sv
// tb/tb_regfile_inexrecur.sv - directed self-checking bench for regfile_inexrecur
module tb_regfile_inexrecur;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              we;
    logic [DATA_W-1:0] w_data;
    logic              seq_re;
    logic              ran_re;
    logic [ADDR_W-1:0] ran_r_addr;
    logic [ADDR_W-1:0] out_r_addr;
    logic [DATA_W-1:0] out_r_data;
`ifdef REGFILE_INEXRECUR_RD_VALID_EN
    logic              out_r_valid;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_inexrecur #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (we),
        .w_data     (w_data),
        .seq_re     (seq_re),
        .ran_re     (ran_re),
        .ran_r_addr (ran_r_addr),
        .out_r_addr (out_r_addr),
        .out_r_data (out_r_data)
`ifdef REGFILE_INEXRECUR_RD_VALID_EN
        ,
        .out_r_valid(out_r_valid)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b0; we = 1'b0; seq_re = 1'b0; ran_re = 1'b0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [ADDR_W-1:0] ea,
                             input logic [DATA_W-1:0] ed, input logic ev);
        check({tag, "_addr"}, 64'(out_r_addr), 64'(ea));
        check({tag, "_data"}, 64'(out_r_data), 64'(ed));
`ifdef REGFILE_INEXRECUR_RD_VALID_EN
        check({tag, "_valid"}, 64'(out_r_valid), 64'(ev));
`else
        if (ev === 1'bx) $display("unused");
`endif
    endtask

    task automatic write(input logic [DATA_W-1:0] d);
        idle(); we = 1'b1; w_data = d;
        tick();
        we = 1'b0;
    endtask

    task automatic seq_read();
        idle(); seq_re = 1'b1;
        tick();
        seq_re = 1'b0;
    endtask

    task automatic ran_read(input logic [ADDR_W-1:0] a);
        idle(); ran_re = 1'b1; ran_r_addr = a;
        tick();
        ran_re = 1'b0;
    endtask

    initial begin
        idle();
        w_data = '0;
        ran_r_addr = '0;
        rst_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        check_out("reset", 12'd0, 32'h0, 1'b0);
        check("reset_wr_ptr", 64'(dut.wr_ptr), 64'd0);
        check("reset_rd_ptr", 64'(dut.rd_ptr), 64'd0);

        write(32'h02010006);
        seq_read();
        check_out("seq0", 12'd0, 32'h02010006, 1'b1);
        tick();
        check_out("idle_hold", 12'd0, 32'h02010006, 1'b0);

        write(32'h01000006);
        seq_read();
        check_out("seq1", 12'd1, 32'h01000006, 1'b1);
        write(32'h02000606);
        seq_read();
        check_out("seq2", 12'd2, 32'h02000606, 1'b1);

        seq_read();
        check_out("seq_empty", 12'd2, 32'h02000606, 1'b0);
        check("seq_empty_rd_ptr", 64'(dut.rd_ptr), 64'd3);

        ran_read(12'd2);
        check_out("ran2", 12'd2, 32'h02000606, 1'b1);
        ran_read(12'd1);
        check_out("ran1", 12'd1, 32'h01000006, 1'b1);
        ran_read(12'd0);
        check_out("ran0", 12'd0, 32'h02010006, 1'b1);
        ran_read(12'd4);
        check_out("ran_oob", 12'd4, 32'h0, 1'b0);
        check("ran_keeps_rd_ptr", 64'(dut.rd_ptr), 64'd3);

        write(32'h0A0B0C0D);
        seq_read();
        check_out("seq3", 12'd3, 32'h0A0B0C0D, 1'b1);

        // empty queue: random read wins over seq, write still lands
        idle(); ran_re = 1'b1; ran_r_addr = 12'd0; seq_re = 1'b1; we = 1'b1; w_data = 32'h11223344;
        tick();
        idle();
        check_out("simul_ran", 12'd0, 32'h02010006, 1'b1);
        check("simul_wr_ptr", 64'(dut.wr_ptr), 64'd5);
        check("simul_rd_ptr", 64'(dut.rd_ptr), 64'd4);
        seq_read();
        check_out("seq4", 12'd4, 32'h11223344, 1'b1);

        // random read of the slot written this same cycle sees no bypass
        idle(); ran_re = 1'b1; ran_r_addr = 12'd5; we = 1'b1; w_data = 32'h55667788;
        tick();
        idle();
        check_out("ran_nobypass", 12'd5, 32'h0, 1'b0);
        ran_read(12'd5);
        check_out("ran5", 12'd5, 32'h55667788, 1'b1);

        // reset overrides an asserted read
        rst_n = 1'b1; ran_re = 1'b1; ran_r_addr = 12'd1; we = 1'b1;
        tick();
        idle();
        check_out("reset_override", 12'd0, 32'h0, 1'b0);
        check("reset2_wr_ptr", 64'(dut.wr_ptr), 64'd0);

        // seq read on empty queue with same-cycle write sees no bypass
        idle(); seq_re = 1'b1; we = 1'b1; w_data = 32'hCAFE0000;
        tick();
        idle();
        check_out("seq_nobypass", 12'd0, 32'h0, 1'b0);
        seq_read();
        check_out("seq_after_reset", 12'd0, 32'hCAFE0000, 1'b1);

        // fill to capacity, then one dropped write
        idle(); we = 1'b1;
        for (int i = 1; i < 4096; i++) begin
            w_data = 32'hA5000000 | 32'(i);
            tick();
        end
        check("full_wr_ptr", 64'(dut.wr_ptr), 64'd4096);
        w_data = 32'hDEADBEEF;
        tick();
        idle();
        check("drop_wr_ptr", 64'(dut.wr_ptr), 64'd4096);
        ran_read(12'd4095);
        check_out("ran_last", 12'd4095, 32'hA5000FFF, 1'b1);
        ran_read(12'd0);
        check_out("ran_first_kept", 12'd0, 32'hCAFE0000, 1'b1);
        seq_read();
        check_out("seq_full", 12'd1, 32'hA5000001, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_inexrecur.md
Name: regfile_inexrecur

Overview:
- Single-port-write, dual-mode-read register file holding 32-bit inexact-recursion entries for the alignment accelerator's backtracking engine.
- Entries are appended in order by the producer.
- Entries can be consumed in arrival order (sequential read) or fetched by index (random read).
- Read results are registered onto a shared address/data output pair.

Parameters:
- DATA_W, 32, entry width in bits.
- ADDR_W, 12, address width; depth = 2**ADDR_W = 4096 entries.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-high reset (name kept from codebase; asserted = 1).
- we  input  1  append w_data at the write pointer this cycle.
- w_data  input  DATA_W  entry to append.
- seq_re  input  1  read the next unread entry, FIFO order.
- ran_re  input  1  random read at ran_r_addr.
- ran_r_addr  input  ADDR_W  random read index.
- out_r_addr  output  ADDR_W  index of the most recently read entry.
- out_r_data  output  DATA_W  data of the most recently read entry.

Behaviour:
- State:
  - wr_ptr (ADDR_W+1 bits): number of valid entries.
  - rd_ptr (ADDR_W+1 bits): next sequential read index.
  - mem[0..DEPTH-1].
- Reset (rst_n=1 at posedge):
  - wr_ptr, rd_ptr, out_r_addr, out_r_data all cleared to 0.
  - mem contents are not cleared.
  - Reset overrides all other inputs in that cycle.
- Write:
  - When we=1 and wr_ptr<DEPTH: mem[wr_ptr]<=w_data; wr_ptr increments.
  - When full (wr_ptr==DEPTH): the write is dropped and no state changes.
  - No wrap-around.
- Read-port priority: ran_re > seq_re; at most one read per cycle.
- Random read (ran_re=1), result at the next edge (1-cycle latency):
  - out_r_addr<=ran_r_addr.
  - out_r_data<=mem[ran_r_addr] if ran_r_addr<wr_ptr, else 0.
  - rd_ptr is unchanged.
- Sequential read (seq_re=1, ran_re=0):
  - If rd_ptr<wr_ptr: out_r_addr<=rd_ptr[ADDR_W-1:0], out_r_data<=mem[rd_ptr], and rd_ptr increments.
  - If empty (rd_ptr==wr_ptr): outputs hold and rd_ptr is unchanged.
- Sequential read with seq_re held high: one entry is consumed per cycle.
- Simultaneous write and read:
  - Emptiness and the random-read bound are evaluated against wr_ptr before this cycle's write.
  - A same-cycle write is therefore not visible to a read in that cycle (no bypass).
- No read asserted: outputs hold their last values.
- Entries already consumed sequentially stay readable by random read until reset.

Optional Feature:
- Macro REGFILE_INEXRECUR_RD_VALID_EN.
- When defined:
  - Adds output out_r_valid (1 bit), reset 0.
  - out_r_valid is 1 for exactly the cycle after a successful read: a random read in range, or a sequential read when not empty.
  - Otherwise out_r_valid is 0. This includes out-of-range random reads that return 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then we=1 for one cycle with 0x02010006, then seq_re=1 for one cycle -> out_r_addr=0, out_r_data=0x02010006.
- Alternate writes of 0x01000006 and 0x02000606, each followed by one seq_re cycle -> reads return addr 1 / 0x01000006, then addr 2 / 0x02000606.
- Extra seq_re pulse with all 3 entries consumed -> outputs hold addr 2 / 0x02000606 and rd_ptr stays 3.
- ran_re=1 with ran_r_addr=2, then 1, then 0 -> outputs 0x02000606, 0x01000006, 0x02010006, each one cycle after the address is applied.
- ran_re=1 with ran_r_addr=4 (beyond wr_ptr=3) -> out_r_addr=4, out_r_data=0. With the macro defined, out_r_valid=0.
- Same cycle: ran_re=1 (addr 0), seq_re=1 and we=1 on an empty queue -> random read wins; the write lands and wr_ptr increments; rd_ptr is unchanged. Separately, 4096 writes followed by one more we=1 -> the extra write is dropped and wr_ptr stays 4096.
